// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the attention-pass instruction sequencer:
// instruction bit map, state encoding and DIV sub-step count.
package inst_sequencer_pkg;

  localparam int INST_W    = 20;
  localparam int ADD_W     = 4;
  localparam int PH_W      = 8;
  localparam int DIV_STEPS = 6;

  // Instruction word bit positions
  localparam int B_FIFO_EXT_RD = 19;
  localparam int B_DIV         = 18;
  localparam int B_ACC         = 17;
  localparam int B_OFIFO_RD    = 16;
  localparam int B_QK_ADD      = 12;  // [15:12]
  localparam int B_P_ADD       = 8;   // [11:8]
  localparam int B_EXECUTE     = 7;
  localparam int B_LOAD        = 6;
  localparam int B_QMEM_RD     = 5;
  localparam int B_QMEM_WR     = 4;
  localparam int B_KMEM_RD     = 3;
  localparam int B_KMEM_WR     = 2;
  localparam int B_PMEM_RD     = 1;
  localparam int B_PMEM_WR     = 0;

  // Declaration order is the pass order; the sequencer advances by +1.
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_QWR,
    ST_QWR_END,
    ST_KWR,
    ST_KWR_END,
    ST_GAP,
    ST_KLOAD,
    ST_KLOAD_E1,
    ST_KLOAD_E2,
    ST_WAIT1,
    ST_EXEC,
    ST_EXEC_END,
    ST_WAIT2,
    ST_MOVE,
    ST_MOVE_END,
    ST_DIV,
    ST_DIV_END
  } st_e;

endpackage

// File: rtl/inst_sequencer_sfp_div_stepper.sv
// DIV phase stepper: advances the shared sub-step/row counters through
// D0..D5 per row and decodes the strobes for the upcoming sub-step.
module sfp_div_stepper
  import inst_sequencer_pkg::*;
#(
  parameter int total_cycle = 8
) (
  input  logic              i_enter,
  input  logic [PH_W-1:0]   i_step,
  input  logic [ADD_W-1:0]  i_row,
  output logic [PH_W-1:0]   o_step_nxt,
  output logic [ADD_W-1:0]  o_row_nxt,
  output logic              o_last,
  output logic [INST_W-1:0] o_inst
);

  logic w_row_inc;

  assign w_row_inc = (i_step == PH_W'(DIV_STEPS - 1));
  assign o_last    = w_row_inc && (i_row == ADD_W'(total_cycle - 1));

  // Next sub-step and row; entering DIV always restarts at D0 of row 0
  always_comb begin
    o_step_nxt = i_step + PH_W'(1);
    o_row_nxt  = i_row;
    if (i_enter) begin
      o_step_nxt = '0;
      o_row_nxt  = '0;
    end else if (w_row_inc) begin
      o_step_nxt = '0;
      o_row_nxt  = i_row + ADD_W'(1);
    end
  end

  // Strobes for the sub-step that will be presented next cycle
  always_comb begin
    o_inst = '0;
    o_inst[B_P_ADD +: ADD_W] = o_row_nxt;
    case (o_step_nxt)
      8'd0: o_inst[B_PMEM_RD] = 1'b1;
      8'd1: begin
        o_inst[B_PMEM_RD] = 1'b1;
        o_inst[B_ACC]     = 1'b1;
      end
      8'd2: o_inst[B_PMEM_RD] = 1'b1;
      8'd3: begin
        o_inst[B_PMEM_RD] = 1'b1;
        o_inst[B_DIV]     = 1'b1;
      end
      8'd4: begin
        o_inst[B_PMEM_WR] = 1'b1;
        o_inst[B_DIV]     = 1'b1;
      end
      default: begin
        o_inst[B_DIV]            = 1'b1;
        o_inst[B_FIFO_EXT_RD]    = 1'b1;
        o_inst[B_P_ADD +: ADD_W] = o_row_nxt + ADD_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/inst_sequencer.sv
// Attention-pass instruction sequencer. One start request walks Q write,
// K write, K load, execute, move and divide, emitting a registered
// instruction word each cycle.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  IDLE        | waiting for start, inst = 0
//  QWR         | write Q rows 0..total_cycle-1
//  QWR_END     | one quiet cycle
//  KWR         | write K rows 0..col-1
//  KWR_END     | one quiet cycle
//  GAP         | gap_cycles quiet cycles before K load
//  KLOAD       | col+1 load cycles, kmem read lags one cycle
//  KLOAD_E1    | final load cycle without kmem read
//  KLOAD_E2    | one quiet cycle
//  WAIT1       | wait_cycles quiet cycles
//  EXEC        | execute rows 0..total_cycle-1
//  EXEC_END    | one quiet cycle
//  WAIT2       | wait_cycles quiet cycles
//  MOVE        | ofifo -> pmem rows 0..total_cycle-1
//  MOVE_END    | one quiet cycle
//  DIV         | D0..D5 per row, driven by sfp_div_stepper
//  DIV_END     | quiet cycle, done pulse
//
// gap_cycles and wait_cycles must be at least 1; total_cycle and col at most 16.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int wait_cycles = 10,
  parameter int gap_cycles  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  st_e               r_state;
  logic [PH_W-1:0]   r_phase;
  logic [ADD_W-1:0]  r_row;
  logic [INST_W-1:0] r_inst;
  logic              r_busy;
  logic              r_done;

  st_e               w_state_nxt;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [ADD_W-1:0]  w_row_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic [PH_W-1:0]   w_len;
  logic              w_end;
  logic [PH_W-1:0]   w_div_step;
  logic [ADD_W-1:0]  w_div_row;
  logic              w_div_last;
  logic [INST_W-1:0] w_div_inst;
  logic [ADD_W-1:0]  w_kload_add;

  sfp_div_stepper #(
    .total_cycle (total_cycle)
  ) u_div_stepper (
    .i_enter    (r_state == ST_MOVE_END),
    .i_step     (r_phase),
    .i_row      (r_row),
    .o_step_nxt (w_div_step),
    .o_row_nxt  (w_div_row),
    .o_last     (w_div_last),
    .o_inst     (w_div_inst)
  );

  // Length of the current state in cycles
  always_comb begin
    w_len = PH_W'(1);
    case (r_state)
      ST_QWR, ST_EXEC, ST_MOVE: w_len = PH_W'(total_cycle);
      ST_KWR:                   w_len = PH_W'(col);
      ST_KLOAD:                 w_len = PH_W'(col + 1);
      ST_GAP:                   w_len = PH_W'(gap_cycles);
      ST_WAIT1, ST_WAIT2:       w_len = PH_W'(wait_cycles);
      default:                  w_len = PH_W'(1);
    endcase
  end

  assign w_end = (r_state == ST_DIV) ? w_div_last : (r_phase == w_len - PH_W'(1));

  // Next state and shared phase/row counters
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PH_W'(1);
    w_row_nxt   = r_row;
    if (r_state == ST_IDLE) begin
      w_phase_nxt = '0;
      w_row_nxt   = '0;
      if (start) w_state_nxt = ST_QWR;
    end else if (w_end) begin
      w_state_nxt = (r_state == ST_DIV_END) ? ST_IDLE : st_e'(r_state + 5'd1);
      w_phase_nxt = '0;
      w_row_nxt   = '0;
    end else if (r_state == ST_DIV) begin
      w_phase_nxt = w_div_step;
      w_row_nxt   = w_div_row;
    end
  end

  // K load address trails the load strobe by one row after the first read
  assign w_kload_add = (w_phase_nxt > PH_W'(1)) ? ADD_W'(w_phase_nxt - PH_W'(1)) : '0;

  // Instruction word for the upcoming cycle
  always_comb begin
    w_inst_nxt = '0;
    case (w_state_nxt)
      ST_QWR: begin
        w_inst_nxt[B_QMEM_WR]            = 1'b1;
        w_inst_nxt[B_QK_ADD +: ADD_W]    = w_phase_nxt[ADD_W-1:0];
      end
      ST_KWR: begin
        w_inst_nxt[B_KMEM_WR]            = 1'b1;
        w_inst_nxt[B_QK_ADD +: ADD_W]    = w_phase_nxt[ADD_W-1:0];
      end
      ST_KLOAD: begin
        w_inst_nxt[B_LOAD]               = 1'b1;
        w_inst_nxt[B_KMEM_RD]            = (w_phase_nxt != '0);
        w_inst_nxt[B_QK_ADD +: ADD_W]    = w_kload_add;
      end
      ST_KLOAD_E1: w_inst_nxt[B_LOAD]    = 1'b1;
      ST_EXEC: begin
        w_inst_nxt[B_EXECUTE]            = 1'b1;
        w_inst_nxt[B_QMEM_RD]            = 1'b1;
        w_inst_nxt[B_QK_ADD +: ADD_W]    = w_phase_nxt[ADD_W-1:0];
      end
      ST_MOVE: begin
        w_inst_nxt[B_OFIFO_RD]           = 1'b1;
        w_inst_nxt[B_PMEM_WR]            = 1'b1;
        w_inst_nxt[B_P_ADD +: ADD_W]     = w_phase_nxt[ADD_W-1:0];
      end
      ST_DIV:  w_inst_nxt = w_div_inst;
      default: w_inst_nxt = '0;
    endcase
  end

  // Sequencer registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_row   <= '0;
      r_inst  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_row   <= w_row_nxt;
      r_inst  <= w_inst_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DIV_END);
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: default pass against a golden table,
// ignored restart, mid-pass reset, and a reduced-parameter pass.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_d = 1'b0;
  logic        start_s = 1'b0;
  logic [19:0] inst_d, inst_s;
  logic        busy_d, busy_s, done_d, done_s;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  logic [19:0] gq[$];
  logic [19:0] gold_d[$];
  logic [19:0] gold_s[$];

  always #5 clk = ~clk;

  inst_sequencer u_dut_d (
    .clk   (clk),
    .reset (reset),
    .start (start_d),
    .inst  (inst_d),
    .busy  (busy_d),
    .done  (done_d)
  );

  inst_sequencer #(
    .total_cycle (4),
    .col         (4),
    .wait_cycles (2),
    .gap_cycles  (1)
  ) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .inst  (inst_s),
    .busy  (busy_s),
    .done  (done_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int v);
    gq.push_back(20'(v));
  endtask

  // Golden pass built phase by phase from the bit map
  task automatic build(input int tc, input int cl, input int wc, input int gc);
    gq.delete();
    for (int i = 0; i < tc; i++) push(32'h10 | (i << 12));
    push(0);
    for (int i = 0; i < cl; i++) push(32'h04 | (i << 12));
    push(0);
    for (int i = 0; i < gc; i++) push(0);
    push(32'h40);
    for (int k = 1; k <= cl; k++) push(32'h48 | (((k == 1) ? 0 : k - 1) << 12));
    push(32'h40);
    push(0);
    for (int i = 0; i < wc; i++) push(0);
    for (int i = 0; i < tc; i++) push(32'hA0 | (i << 12));
    push(0);
    for (int i = 0; i < wc; i++) push(0);
    for (int i = 0; i < tc; i++) push(32'h10001 | (i << 8));
    push(0);
    for (int r = 0; r < tc; r++) begin
      push(32'h00002 | (r << 8));
      push(32'h20002 | (r << 8));
      push(32'h00002 | (r << 8));
      push(32'h40002 | (r << 8));
      push(32'h40001 | (r << 8));
      push(32'hC0000 | (((r + 1) % 16) << 8));
    end
    push(0);
  endtask

  // Default instance: pulse start, then check n cycles of the pass
  task automatic run_def(input int n, input int pulse_at);
    n_done = 0;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("inst", inst_d, gold_d[i]);
      chk("busy", busy_d, 1);
      chk("done", done_d, (i == 117) ? 1 : 0);
      if (i == 21)  chk("kload_k1", inst_d, 20'h00048);
      if (i == 116) chk("d5_row7", inst_d, 20'hC0800);
      if (done_d) n_done++;
      start_d = (i == pulse_at);
      @(negedge clk);
    end
  endtask

  initial begin
    build(8, 8, 10, 2);
    gold_d = gq;
    build(4, 4, 2, 1);
    gold_s = gq;

    repeat (3) @(negedge clk);
    chk("rst_inst", inst_d, 0);
    chk("rst_busy", busy_d, 0);
    chk("rst_done", done_d, 0);
    chk("rst_inst_s", inst_s, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_inst", inst_d, 0);
    chk("idle_busy", busy_d, 0);

    // Full pass with a stray start mid-pass
    run_def(118, 50);
    chk("done_count", n_done, 1);
    chk("end_inst", inst_d, 0);
    chk("end_busy", busy_d, 0);
    chk("end_done", done_d, 0);
    repeat (3) begin
      @(negedge clk);
      chk("post_inst", inst_d, 0);
      chk("post_busy", busy_d, 0);
    end

    // Abort during EXEC row 3
    run_def(44, -1);
    chk("exec_r3", inst_d, gold_d[44]);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_inst", inst_d, 0);
    chk("abort_busy", busy_d, 0);
    chk("abort_done", done_d, 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_idle_inst", inst_d, 0);
      chk("abort_idle_done", done_d, 0);
    end

    // Fresh pass replays from QWR row 0
    run_def(118, -1);
    chk("replay_done_count", n_done, 1);
    chk("replay_end_busy", busy_d, 0);

    // Reduced-parameter instance
    n_done = 0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 57; i++) begin
      chk("s_inst", inst_s, gold_s[i]);
      chk("s_busy", busy_s, 1);
      chk("s_done", done_s, (i == 56) ? 1 : 0);
      if (i == 30) chk("s_last_move_add", inst_s[11:8], 3);
      if (i == 55) chk("s_last_d5_add", inst_s[11:8], 4);
      if (done_s) n_done++;
      @(negedge clk);
    end
    chk("s_done_count", n_done, 1);
    chk("s_end_inst", inst_s, 0);
    chk("s_end_busy", busy_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
